// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_pkg
//  Description : Shared constants for the load/store unit: one-hot state
//                encoding and store byte-lane request codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // One-hot FSM state encoding
    localparam logic [2:0] c_IDLE       = 3'b001;
    localparam logic [2:0] c_LOAD_WAIT  = 3'b010;
    localparam logic [2:0] c_STORE_WAIT = 3'b100;

    // Store lane requests: [1] = even/high byte, [0] = odd/low byte
    localparam logic [1:0] c_LANE_HI   = 2'b10;
    localparam logic [1:0] c_LANE_LO   = 2'b01;
    localparam logic [1:0] c_LANE_WORD = 2'b11;

endpackage : mem_access_unit_pkg
`default_nettype wire

// File: rtl/mem_access_unit_load_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : load_formatter
//  Description : Combinational load-data formatter. Selects the addressed
//                byte of a big-endian word (even = [15:8], odd = [7:0]) and
//                zero- or sign-extends it; word accesses pass straight through.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_formatter (
    input  wire logic [15:0] i_readdat,
    input  wire logic        i_byte,
    input  wire logic        i_signed,
    input  wire logic        i_addr0,
    output logic      [15:0] o_data
);

    logic [7:0] w_byte_sel;
    logic [7:0] w_ext;

    // Pick the addressed lane and build the upper-byte extension
    always_comb begin
        w_byte_sel = i_addr0 ? i_readdat[7:0] : i_readdat[15:8];
        w_ext      = i_signed ? {8{w_byte_sel[7]}} : 8'h00;
        o_data     = i_byte ? {w_ext, w_byte_sel} : i_readdat;
    end

endmodule : load_formatter
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store unit. Accepts one command at a time, drives the
//                memory controller store port (path 2) or load port (path 3),
//                waits for done with a timeout, and returns formatted load
//                data with a one-cycle completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_W          = 7
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        op_valid,
    output logic             op_ready,
    input  wire logic        op_store,
    input  wire logic        op_byte,
    input  wire logic        op_signed,
    input  wire logic [15:0] op_addr,
    input  wire logic [15:0] op_wdata,
    output logic             res_valid,
    output logic      [15:0] res_data,
    output logic             res_err,
    output logic      [15:0] st_addr,
    output logic      [15:0] st_wdata,
    output logic       [1:0] st_request,
    input  wire logic        st_done,
    output logic      [15:0] ld_addr,
    output logic             ld_request,
    input  wire logic        ld_done,
    input  wire logic [15:0] ld_readdat
);

    // The last count value before the timeout edge; the timeout fires on the
    // TIMEOUT_CYCLES-th edge spent in a wait state.
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       r_state;
    logic [TMO_W-1:0] r_cnt;
    logic             r_byte;
    logic             r_signed;
    logic             r_addr0;
    logic             r_res_valid;
    logic [15:0]      r_res_data;
    logic             r_res_err;
    logic [15:0]      r_st_addr;
    logic [15:0]      r_st_wdata;
    logic [1:0]       r_st_request;
    logic [15:0]      r_ld_addr;
    logic             r_ld_request;
    logic [15:0]      w_fmt_data;

    load_formatter u_load_formatter (
        .i_readdat (ld_readdat),
        .i_byte    (r_byte),
        .i_signed  (r_signed),
        .i_addr0   (r_addr0),
        .o_data    (w_fmt_data)
    );

    // Command FSM: accept, issue request, wait for done or timeout, respond.
    // Requests drop on the same edge that samples done so none is re-issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_byte       <= 1'b0;
            r_signed     <= 1'b0;
            r_addr0      <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= 16'h0000;
            r_res_err    <= 1'b0;
            r_st_addr    <= 16'h0000;
            r_st_wdata   <= 16'h0000;
            r_st_request <= 2'b00;
            r_ld_addr    <= 16'h0000;
            r_ld_request <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (op_valid) begin
                        if (!op_byte && op_addr[0]) begin
                            // Misaligned word: reject without touching memory
                            r_res_valid <= 1'b1;
                            r_res_err   <= 1'b1;
                            r_res_data  <= 16'h0000;
                        end else begin
                            r_cnt    <= '0;
                            r_byte   <= op_byte;
                            r_signed <= op_signed;
                            r_addr0  <= op_addr[0];
                            if (op_store) begin
                                r_st_addr    <= op_addr;
                                r_st_wdata   <= op_byte ? {8'h00, op_wdata[7:0]} : op_wdata;
                                r_st_request <= !op_byte   ? c_LANE_WORD :
                                                op_addr[0] ? c_LANE_LO : c_LANE_HI;
                                r_state      <= c_STORE_WAIT;
                            end else begin
                                r_ld_addr    <= op_addr;
                                r_ld_request <= 1'b1;
                                r_state      <= c_LOAD_WAIT;
                            end
                        end
                    end
                end
                c_LOAD_WAIT: begin
                    if (ld_done) begin
                        r_ld_request <= 1'b0;
                        r_res_valid  <= 1'b1;
                        r_res_data   <= w_fmt_data;
                        r_state      <= c_IDLE;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_ld_request <= 1'b0;
                        r_res_valid  <= 1'b1;
                        r_res_err    <= 1'b1;
                        r_res_data   <= 16'h0000;
                        r_state      <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TMO_W'(1);
                    end
                end
                c_STORE_WAIT: begin
                    if (st_done) begin
                        r_st_request <= 2'b00;
                        r_res_valid  <= 1'b1;
                        r_res_data   <= 16'h0000;
                        r_state      <= c_IDLE;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_st_request <= 2'b00;
                        r_res_valid  <= 1'b1;
                        r_res_err    <= 1'b1;
                        r_res_data   <= 16'h0000;
                        r_state      <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    r_state      <= c_IDLE;
                    r_st_request <= 2'b00;
                    r_ld_request <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready   = (r_state == c_IDLE);
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_err    = r_res_err;
    assign st_addr    = r_st_addr;
    assign st_wdata   = r_st_wdata;
    assign st_request = r_st_request;
    assign ld_addr    = r_ld_addr;
    assign ld_request = r_ld_request;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. Expected responses
//                are queued when a command is driven and compared when
//                res_valid pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int c_TMO  = 8;
    localparam int c_TMOW = 4;

    logic        clk;
    logic        reset_n;
    logic        op_valid;
    logic        op_ready;
    logic        op_store;
    logic        op_byte;
    logic        op_signed;
    logic [15:0] op_addr;
    logic [15:0] op_wdata;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_err;
    logic [15:0] st_addr;
    logic [15:0] st_wdata;
    logic [1:0]  st_request;
    logic        st_done;
    logic [15:0] ld_addr;
    logic        ld_request;
    logic        ld_done;
    logic [15:0] ld_readdat;

    int          r_checks;
    int          r_failures;
    logic [16:0] r_sb[$];

    mem_access_unit #(
        .TIMEOUT_CYCLES (c_TMO),
        .TMO_W          (c_TMOW)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_store   (op_store),
        .op_byte    (op_byte),
        .op_signed  (op_signed),
        .op_addr    (op_addr),
        .op_wdata   (op_wdata),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_err    (res_err),
        .st_addr    (st_addr),
        .st_wdata   (st_wdata),
        .st_request (st_request),
        .st_done    (st_done),
        .ld_addr    (ld_addr),
        .ld_request (ld_request),
        .ld_done    (ld_done),
        .ld_readdat (ld_readdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference load formatting for big-endian byte lanes
    function automatic logic [15:0] model_fmt(input logic [15:0] rd, input logic bt,
                                              input logic sg, input logic a0);
        logic [7:0] b;
        b = a0 ? rd[7:0] : rd[15:8];
        if (!bt) return rd;
        return sg ? {{8{b[7]}}, b} : {8'h00, b};
    endfunction

    // Scoreboard: every completion pulse must match the oldest expectation
    always @(negedge clk) begin
        if (res_valid) begin
            if (r_sb.size() == 0) begin
                check("stray_res_valid", {31'd0, res_valid}, 32'd0);
            end else begin
                logic [16:0] e;
                e = r_sb.pop_front();
                check("res_data", {16'd0, res_data}, {16'd0, e[15:0]});
                check("res_err", {31'd0, res_err}, {31'd0, e[16]});
            end
        end
    end

    // Drive one command starting at a negedge; done_after=0 means never answer
    task automatic run_op(input logic st, input logic bt, input logic sg,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata, input int done_after,
                          input logic [15:0] exp_data, input logic exp_err);
        logic [1:0]  exp_lane;
        logic [15:0] exp_wdata;
        int          limit;
        exp_lane  = !bt ? 2'b11 : (addr[0] ? 2'b01 : 2'b10);
        exp_wdata = bt ? {8'h00, wdata[7:0]} : wdata;
        limit     = (done_after > 0) ? done_after : c_TMO;

        check("op_ready_pre", {31'd0, op_ready}, 32'd1);
        op_valid  = 1'b1;
        op_store  = st;
        op_byte   = bt;
        op_signed = sg;
        op_addr   = addr;
        op_wdata  = wdata;
        r_sb.push_back({exp_err, exp_data});
        @(negedge clk);
        // Scramble command inputs to prove the unit latched them
        op_valid  = 1'b0;
        op_store  = ~st;
        op_byte   = ~bt;
        op_signed = ~sg;
        op_addr   = ~addr;
        op_wdata  = 16'($urandom);

        if (!bt && addr[0]) begin
            check("misalign_ld_req", {31'd0, ld_request}, 32'd0);
            check("misalign_st_req", {30'd0, st_request}, 32'd0);
            check("misalign_ready", {31'd0, op_ready}, 32'd1);
            #1;
            check("sb_drained", r_sb.size(), 32'd0);
            return;
        end

        for (int k = 1; k <= limit; k++) begin
            st_done = 1'b0;
            ld_done = 1'b0;
            if (st) begin
                check("st_request", {30'd0, st_request}, {30'd0, exp_lane});
                check("ld_req_idle", {31'd0, ld_request}, 32'd0);
                if (k == 1) begin
                    check("st_addr", {16'd0, st_addr}, {16'd0, addr});
                    check("st_wdata", {16'd0, st_wdata}, {16'd0, exp_wdata});
                end
            end else begin
                check("ld_request", {31'd0, ld_request}, 32'd1);
                check("st_req_idle", {30'd0, st_request}, 32'd0);
                if (k == 1) check("ld_addr", {16'd0, ld_addr}, {16'd0, addr});
            end
            check("op_ready_busy", {31'd0, op_ready}, 32'd0);
            // A done on the unused port must be ignored
            if (k == 1 && done_after != 1) begin
                if (st) ld_done = 1'b1;
                else    st_done = 1'b1;
                ld_readdat = 16'($urandom);
            end
            if (k == done_after) begin
                if (st) st_done = 1'b1;
                else    ld_done = 1'b1;
                ld_readdat = rdata;
            end
            @(negedge clk);
        end
        st_done    = 1'b0;
        ld_done    = 1'b0;
        ld_readdat = 16'($urandom);
        check("req_dropped_ld", {31'd0, ld_request}, 32'd0);
        check("req_dropped_st", {30'd0, st_request}, 32'd0);
        check("op_ready_post", {31'd0, op_ready}, 32'd1);
        #1;
        check("sb_drained", r_sb.size(), 32'd0);
    endtask

    initial begin
        r_checks   = 0;
        r_failures = 0;
        reset_n    = 1'b0;
        op_valid   = 1'b0;
        op_store   = 1'b0;
        op_byte    = 1'b0;
        op_signed  = 1'b0;
        op_addr    = 16'h0000;
        op_wdata   = 16'h0000;
        st_done    = 1'b0;
        ld_done    = 1'b0;
        ld_readdat = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_err", {31'd0, res_err}, 32'd0);
        check("rst_res_data", {16'd0, res_data}, 32'd0);
        check("rst_st_request", {30'd0, st_request}, 32'd0);
        check("rst_ld_request", {31'd0, ld_request}, 32'd0);
        check("rst_addrs", {st_addr, ld_addr}, 32'd0);
        check("rst_st_wdata", {16'd0, st_wdata}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Word load, done after 3 cycles
        run_op(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3, 16'hBEEF, 1'b0);
        // Byte loads, back-to-back
        run_op(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 16'h80F1, 2, 16'hFF80, 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 16'h80F1, 1, 16'h00F1, 1'b0);
        run_op(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 16'h80F1, 2, 16'hFFF1, 1'b0);
        // Byte and word stores
        run_op(1'b1, 1'b1, 1'b0, 16'h0031, 16'h12AB, 16'h0000, 2, 16'h0000, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 16'h0030, 16'h12AB, 16'h0000, 3, 16'h0000, 1'b0);
        run_op(1'b1, 1'b0, 1'b0, 16'h0032, 16'h5A3C, 16'h0000, 1, 16'h0000, 1'b0);
        // Misaligned word accesses
        run_op(1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000, 16'h0000, 1, 16'h0000, 1'b1);
        run_op(1'b1, 1'b0, 1'b0, 16'h0043, 16'h7777, 16'h0000, 1, 16'h0000, 1'b1);
        // Timeouts, then done on the timeout edge
        run_op(1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0000, 0, 16'h0000, 1'b1);
        run_op(1'b1, 1'b1, 1'b0, 16'h0051, 16'h00CD, 16'h0000, 0, 16'h0000, 1'b1);
        run_op(1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000, 16'hC0DE, c_TMO, 16'hC0DE, 1'b0);
        run_op(1'b1, 1'b0, 1'b0, 16'h0062, 16'h4321, 16'h0000, c_TMO, 16'h0000, 1'b0);

        // Randomised aligned loads against the reference formatter
        for (int i = 0; i < 8; i++) begin
            logic        bt;
            logic        sg;
            logic [15:0] a;
            logic [15:0] rd;
            bt = 1'($urandom);
            sg = 1'($urandom);
            a  = 16'($urandom);
            if (!bt) a[0] = 1'b0;
            rd = 16'($urandom);
            run_op(1'b0, bt, sg, a, 16'h0000, rd, int'($urandom_range(1, 4)),
                   model_fmt(rd, bt, sg, a[0]), 1'b0);
        end

        // Reset asserted mid-load: outputs clear at once, no response follows
        op_valid = 1'b1;
        op_store = 1'b0;
        op_byte  = 1'b0;
        op_addr  = 16'h0070;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_ld_request", {31'd0, ld_request}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_ld_request", {31'd0, ld_request}, 32'd0);
        check("async_rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("async_rst_ld_addr", {16'd0, ld_addr}, 32'd0);
        @(negedge clk);
        reset_n    = 1'b1;
        ld_done    = 1'b1;
        st_done    = 1'b1;
        ld_readdat = 16'hDEAD;
        @(negedge clk);
        ld_done = 1'b0;
        st_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("no_stray_valid", {31'd0, res_valid}, 32'd0);
            @(negedge clk);
        end

        // Unit still usable after the abandoned access
        run_op(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'hA55A, 2, 16'h00A5, 1'b0);
        repeat (2) @(negedge clk);
        check("sb_empty_end", r_sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_access_unit
`default_nettype wire
